// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD write driver: a small word FIFO feeding a four-state
// bus sequencer (data setup, EN strobe, post-command execution wait).
module lcd_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int EN_SETUP_CYC = 2,
  parameter int EN_PULSE_CYC = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_wr_valid,
  input  logic [8:0]                    i_wr_data,
  output logic                          o_wr_ready,
  input  logic                          i_lcd_on,
  output logic [7:0]                    o_lcd_data,
  output logic                          o_lcd_rs,
  output logic                          o_lcd_rw,
  output logic                          o_lcd_en,
  output logic                          o_lcd_on,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int MAX_AB  = (EN_SETUP_CYC > EN_PULSE_CYC) ? EN_SETUP_CYC : EN_PULSE_CYC;
  localparam int MAX_CD  = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic               lcd_rs_q, lcd_rs_d;
  logic               lcd_en_q, lcd_en_d;
  logic               lcd_on_q, lcd_on_d;
  logic [8:0]         mem_q [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic [8:0]         head;
  logic               is_clear_cmd;

  assign o_wr_ready = (level_q != LVL_W'(FIFO_DEPTH));
  assign push       = i_wr_valid && o_wr_ready;
  assign head       = mem_q[rd_ptr_q];

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_clear_cmd = !lcd_rs_q && (lcd_data_q[7:2] == 6'd0) && (lcd_data_q[1:0] != 2'd0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_en_d   = lcd_en_q;
    pop        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop        = 1'b1;
          lcd_data_d = head[7:0];
          lcd_rs_d   = head[8];
          lcd_en_d   = 1'b0;
          cnt_d      = CNT_W'(EN_SETUP_CYC);
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          lcd_en_d = 1'b1;
          cnt_d    = CNT_W'(EN_PULSE_CYC);
          state_d  = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          lcd_en_d = 1'b0;
          cnt_d    = is_clear_cmd ? CNT_W'(CLR_WAIT_CYC) : CNT_W'(CMD_WAIT_CYC);
          state_d  = ST_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    lcd_on_d = i_lcd_on;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      lcd_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      lcd_on_q   <= lcd_on_d;
    end
  end

  // NOTE: FIFO storage is not reset; the level/pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_lcd_data = lcd_data_q;
  assign o_lcd_rs   = lcd_rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = lcd_en_q;
  assign o_lcd_on   = lcd_on_q;
  assign o_level    = level_q;
  assign o_busy     = (state_q != ST_IDLE) || (level_q != '0);

endmodule
